// File: rtl/up_counter_if.sv
// Control and status bundle for up_counter: count controls in, count state out.
interface up_counter_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic             enable;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] q;
    logic             carry;
    logic             wrap;
    logic             load_error;
    logic [7:0]       wrap_count;

    modport master (
        output enable, clear, load, load_value,
        input  q, carry, wrap, load_error, wrap_count
    );

    modport slave (
        input  enable, clear, load, load_value,
        output q, carry, wrap, load_error, wrap_count
    );
endinterface

// File: rtl/up_counter.sv
// Modulo-N up counter with sync clear/load, range-checked load, wrap pulse
// and a saturating wrap event counter.
module up_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input logic         clock,
    input logic         reset,
    up_counter_if.slave bus
);
    localparam int unsigned    WC_W    = 8;
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] TERM  = WIDTH'(MODULUS - 1);
    localparam logic [WC_W-1:0]  WC_MAX = {WC_W{1'b1}};

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic             load_error_r;
    logic [WC_W-1:0]  wrap_count_r;
    logic             at_term_c;
    logic             load_oor_c;

    assign at_term_c  = (q_r == TERM);
    // Extra MSB makes the comparison vacuous when MODULUS == 2**WIDTH.
    assign load_oor_c = ({1'b0, bus.load_value} >= MOD_EXT);

    // Count state: clear > load > enable > hold; pulses default low each cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_r          <= '0;
            wrap_r       <= 1'b0;
            load_error_r <= 1'b0;
            wrap_count_r <= '0;
        end else begin
            wrap_r       <= 1'b0;
            load_error_r <= 1'b0;
            if (bus.clear) begin
                q_r <= '0;
            end else if (bus.load) begin
                if (load_oor_c) begin
                    q_r          <= TERM;
                    load_error_r <= 1'b1;
                end else begin
                    q_r <= bus.load_value;
                end
            end else if (bus.enable) begin
                if (at_term_c) begin
                    q_r    <= '0;
                    wrap_r <= 1'b1;
                    if (wrap_count_r != WC_MAX) begin
                        wrap_count_r <= wrap_count_r + WC_W'(1);
                    end
                end else begin
                    q_r <= q_r + WIDTH'(1);
                end
            end
        end
    end

    assign bus.q          = q_r;
    assign bus.wrap       = wrap_r;
    assign bus.load_error = load_error_r;
    assign bus.wrap_count = wrap_count_r;
    // Terminal count for cascading; zero-delay from the control inputs.
    assign bus.carry      = at_term_c & bus.enable & ~bus.clear & ~bus.load;
endmodule

// File: tb/tb_up_counter.sv
// Directed bench for up_counter: modulus 10, modulus 2 (saturation) and a
// full-range modulus 8 instance.
module tb_up_counter;
    logic clock;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    up_counter_if #(.WIDTH(4)) a_if ();
    up_counter_if #(.WIDTH(4)) b_if ();
    up_counter_if #(.WIDTH(3)) c_if ();

    up_counter #(.WIDTH(4), .MODULUS(10)) dut_a (.clock(clock), .reset(reset), .bus(a_if.slave));
    up_counter #(.WIDTH(4), .MODULUS(2))  dut_b (.clock(clock), .reset(reset), .bus(b_if.slave));
    up_counter #(.WIDTH(3), .MODULUS(8))  dut_c (.clock(clock), .reset(reset), .bus(c_if.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_a();
        a_if.enable = 1'b0; a_if.clear = 1'b0; a_if.load = 1'b0; a_if.load_value = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_a();
        b_if.enable = 1'b0; b_if.clear = 1'b0; b_if.load = 1'b0; b_if.load_value = '0;
        c_if.enable = 1'b0; c_if.clear = 1'b0; c_if.load = 1'b0; c_if.load_value = '0;
        a_if.enable = 1'b1;
        #12;
        total_cnt++;
        if ({a_if.q, a_if.wrap, a_if.load_error, a_if.wrap_count, a_if.carry} !== 15'd0)
            $display("FAIL reset_state: q=%0d wrap=%b lerr=%b wc=%0d carry=%b, want all 0",
                     a_if.q, a_if.wrap, a_if.load_error, a_if.wrap_count, a_if.carry);
        else pass_cnt++;
        a_if.enable = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_free_count();
        int exp_q [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        a_if.enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            total_cnt++;
            if (a_if.q !== 4'(exp_q[i]) || a_if.wrap !== (exp_q[i] == 0))
                $display("FAIL free_count[%0d]: q=%0d wrap=%b, want q=%0d wrap=%b",
                         i, a_if.q, a_if.wrap, exp_q[i], exp_q[i] == 0);
            else pass_cnt++;
        end
        total_cnt++;
        if (a_if.wrap_count !== 8'd1)
            $display("FAIL free_wrap_count: got %0d want 1", a_if.wrap_count);
        else pass_cnt++;
        a_if.enable = 1'b0;
        tick();
        total_cnt++;
        if (a_if.q !== 4'd2 || a_if.wrap !== 1'b0)
            $display("FAIL hold: q=%0d wrap=%b want q=2 wrap=0", a_if.q, a_if.wrap);
        else pass_cnt++;
    endtask

    task automatic test_load();
        a_if.load = 1'b1; a_if.load_value = 4'd7;
        tick();
        total_cnt++;
        if (a_if.q !== 4'd7 || a_if.load_error !== 1'b0)
            $display("FAIL load_7: q=%0d lerr=%b want q=7 lerr=0", a_if.q, a_if.load_error);
        else pass_cnt++;
        a_if.load_value = 4'd12;
        tick();
        total_cnt++;
        if (a_if.q !== 4'd9 || a_if.load_error !== 1'b1)
            $display("FAIL load_12: q=%0d lerr=%b want q=9 lerr=1", a_if.q, a_if.load_error);
        else pass_cnt++;
        idle_a();
        tick();
        total_cnt++;
        if (a_if.q !== 4'd9 || a_if.load_error !== 1'b0 || a_if.wrap_count !== 8'd1)
            $display("FAIL load_err_drop: q=%0d lerr=%b wc=%0d want q=9 lerr=0 wc=1",
                     a_if.q, a_if.load_error, a_if.wrap_count);
        else pass_cnt++;
    endtask

    task automatic test_priority();
        a_if.load = 1'b1; a_if.load_value = 4'd5;
        tick();
        a_if.clear = 1'b1; a_if.enable = 1'b1; a_if.load_value = 4'd3;
        tick();
        total_cnt++;
        if (a_if.q !== 4'd0)
            $display("FAIL prio_clear: q=%0d want 0", a_if.q);
        else pass_cnt++;
        a_if.clear = 1'b0;
        tick();
        total_cnt++;
        if (a_if.q !== 4'd3)
            $display("FAIL prio_load: q=%0d want 3", a_if.q);
        else pass_cnt++;
        // Load to 0 from terminal count must not look like a wrap.
        a_if.load_value = 4'd9;
        tick();
        a_if.load_value = 4'd0;
        tick();
        total_cnt++;
        if (a_if.q !== 4'd0 || a_if.wrap !== 1'b0 || a_if.wrap_count !== 8'd1)
            $display("FAIL load0_at_term: q=%0d wrap=%b wc=%0d want q=0 wrap=0 wc=1",
                     a_if.q, a_if.wrap, a_if.wrap_count);
        else pass_cnt++;
        idle_a();
    endtask

    task automatic test_carry();
        a_if.load = 1'b1; a_if.load_value = 4'd9;
        tick();
        a_if.load = 1'b0; a_if.enable = 1'b1;
        #1;
        total_cnt++;
        if (a_if.carry !== 1'b1) $display("FAIL carry_on: got %b want 1", a_if.carry);
        else pass_cnt++;
        a_if.enable = 1'b0;
        #1;
        total_cnt++;
        if (a_if.carry !== 1'b0) $display("FAIL carry_no_en: got %b want 0", a_if.carry);
        else pass_cnt++;
        a_if.enable = 1'b1; a_if.load = 1'b1;
        #1;
        total_cnt++;
        if (a_if.carry !== 1'b0) $display("FAIL carry_load: got %b want 0", a_if.carry);
        else pass_cnt++;
        a_if.load = 1'b0; a_if.clear = 1'b1;
        #1;
        total_cnt++;
        if (a_if.carry !== 1'b0) $display("FAIL carry_clear: got %b want 0", a_if.carry);
        else pass_cnt++;
        idle_a();
    endtask

    task automatic test_async_reset();
        a_if.load = 1'b1; a_if.load_value = 4'd6;
        tick();
        idle_a();
        #2 reset = 1'b0;
        #1;
        total_cnt++;
        if (a_if.q !== 4'd0 || a_if.wrap_count !== 8'd0)
            $display("FAIL async_reset: q=%0d wc=%0d want 0 0", a_if.q, a_if.wrap_count);
        else pass_cnt++;
        reset = 1'b1;
        a_if.enable = 1'b1;
        tick();
        total_cnt++;
        if (a_if.q !== 4'd1) $display("FAIL resume: q=%0d want 1", a_if.q);
        else pass_cnt++;
        // A wrap pulse in flight is discarded by reset.
        a_if.enable = 1'b0; a_if.load = 1'b1; a_if.load_value = 4'd9;
        tick();
        a_if.load = 1'b0; a_if.enable = 1'b1;
        tick();
        total_cnt++;
        if (a_if.wrap !== 1'b1 || a_if.wrap_count !== 8'd1)
            $display("FAIL pre_reset_wrap: wrap=%b wc=%0d want 1 1", a_if.wrap, a_if.wrap_count);
        else pass_cnt++;
        a_if.enable = 1'b0;
        #1 reset = 1'b0;
        #1;
        total_cnt++;
        if (a_if.wrap !== 1'b0 || a_if.wrap_count !== 8'd0)
            $display("FAIL reset_kills_wrap: wrap=%b wc=%0d want 0 0", a_if.wrap, a_if.wrap_count);
        else pass_cnt++;
        reset = 1'b1;
        idle_a();
    endtask

    task automatic test_full_range();
        c_if.load = 1'b1; c_if.load_value = 3'd7;
        tick();
        total_cnt++;
        if (c_if.q !== 3'd7 || c_if.load_error !== 1'b0)
            $display("FAIL full_load7: q=%0d lerr=%b want 7 0", c_if.q, c_if.load_error);
        else pass_cnt++;
        c_if.load = 1'b0; c_if.enable = 1'b1;
        tick();
        total_cnt++;
        if (c_if.q !== 3'd0 || c_if.wrap !== 1'b1 || c_if.wrap_count !== 8'd1)
            $display("FAIL full_wrap: q=%0d wrap=%b wc=%0d want 0 1 1",
                     c_if.q, c_if.wrap, c_if.wrap_count);
        else pass_cnt++;
        c_if.enable = 1'b0;
    endtask

    task automatic test_saturation();
        int wraps = 0;
        logic [3:0] exp_q;
        logic [7:0] exp_wc;
        b_if.enable = 1'b1;
        for (int i = 0; i < 600; i++) begin
            tick();
            exp_q = 4'((i + 1) % 2);
            if (exp_q == 4'd0) wraps++;
            exp_wc = (wraps > 255) ? 8'd255 : 8'(wraps);
            total_cnt++;
            if (b_if.q !== exp_q || b_if.wrap !== (exp_q == 4'd0) || b_if.wrap_count !== exp_wc)
                $display("FAIL saturate[%0d]: q=%0d wrap=%b wc=%0d want q=%0d wrap=%b wc=%0d",
                         i, b_if.q, b_if.wrap, b_if.wrap_count, exp_q, exp_q == 4'd0, exp_wc);
            else pass_cnt++;
        end
        b_if.enable = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_free_count();
        test_load();
        test_priority();
        test_carry();
        test_async_reset();
        test_full_range();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
